// File: rtl/cpu_pkg.sv
// Shared CPU control types: sequencer states, decoder instruction codes, reset vector.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        EXEC1  = 2'd1,
        EXEC2  = 2'd2,
        HALTED = 2'd3
    } state_t;

    typedef enum logic [6:0] {
        NOP   = 7'd0,
        ADD   = 7'd1,
        ADDU  = 7'd2,
        SUB   = 7'd3,
        ADDIU = 7'd4,
        LUI   = 7'd5,
        OR    = 7'd6,
        LW    = 7'd7,
        SW    = 7'd8,
        BEQ   = 7'd9,
        BNE   = 7'd10,
        J     = 7'd11,
        JAL   = 7'd12,
        JR    = 7'd13,
        JALR  = 7'd14,
        MULT  = 7'd15,
        DIV   = 7'd16,
        MFHI  = 7'd17,
        MFLO  = 7'd18
    } code_def;

    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

    // Register-indirect and absolute jumps never touch data memory.
    function automatic logic is_jump(input code_def c);
        return (c == J) || (c == JAL) || (c == JR) || (c == JALR);
    endfunction

endpackage

// File: rtl/instr_reg.sv
// 32-bit instruction register with synchronous reset and load enable.
// Latency: 1 cycle from load to q.
// Backpressure: none; holds value whenever load is low.
module instr_reg #(
    parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] d,
    output logic [31:0] q
);

    // Capture the fetched word; reset has priority over a pending load.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= RESET_VAL;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/cycle_sequencer.sv
// Multi-cycle CPU control FSM: FETCH/EXEC1/EXEC2 phase strobes, IR ownership, halt detect.
// Latency: 3 cycles per instruction minimum (FETCH, EXEC1, EXEC2); strobes are registered.
// Backpressure: waitrequest holds FETCH; mem_op&waitrequest or muldiv_busy holds EXEC2.
// Optional build macro PERF_CNT_EN adds retired/stall performance counters.
import cpu_pkg::*;

module cycle_sequencer #(
    parameter logic [31:0] IR_RESET = RESET_VECTOR
`ifdef PERF_CNT_EN
    ,
    parameter int unsigned CNT_W = 32
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    input  logic [6:0]  instruction_code,
    input  logic        mem_op,
    input  logic        muldiv_busy,
    input  logic        halt_req,
    output logic        fetch,
    output logic        exec_one,
    output logic        exec_two,
    output logic        instr_read,
    output logic [31:0] instruction,
    output logic        pc_en,
    output logic        active
`ifdef PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] retired_count,
    output logic [CNT_W-1:0] stall_count
`endif
);

    state_t state;
    state_t next_state;
    logic   hold;
    logic   ir_load;

    // Next-state decode; hold flags a cycle where the current phase is stalled.
    always_comb begin
        next_state = state;
        hold       = 1'b0;
        case (state)
            FETCH: begin
                if (waitrequest) begin
                    hold = 1'b1;
                end else begin
                    next_state = EXEC1;
                end
            end
            EXEC1: begin
                next_state = EXEC2;
            end
            EXEC2: begin
                // Stall outranks halt, so a halting instruction still finishes its access.
                if ((mem_op && waitrequest) || muldiv_busy) begin
                    hold = 1'b1;
                end else if (halt_req) begin
                    next_state = HALTED;
                end else begin
                    next_state = FETCH;
                end
            end
            HALTED: begin
                next_state = HALTED;
            end
            default: begin
                next_state = FETCH;
            end
        endcase
    end

    // Retire strobe is gated by reset so an interrupted instruction never updates the PC.
    assign pc_en      = (state == EXEC2) && !hold && !reset;
    assign instr_read = (state == FETCH);
    assign ir_load    = (state == FETCH) && !waitrequest;

    // State register plus registered one-hot phase strobes and active flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FETCH;
            fetch    <= 1'b1;
            exec_one <= 1'b0;
            exec_two <= 1'b0;
            active   <= 1'b1;
        end else begin
            state    <= next_state;
            fetch    <= (next_state == FETCH);
            exec_one <= (next_state == EXEC1);
            exec_two <= (next_state == EXEC2);
            active   <= (next_state != HALTED);
        end
    end

    instr_reg #(
        .RESET_VAL (IR_RESET)
    ) u_instr_reg (
        .clk   (clk),
        .reset (reset),
        .load  (ir_load),
        .d     (readdata),
        .q     (instruction)
    );

    // Jumps must not claim a data access; a violation means the decoder is broken.
    a_jump_no_mem : assert property (
        @(posedge clk) disable iff (reset)
        ((state == EXEC2) && is_jump(code_def'(instruction_code))) |-> !mem_op
    );

`ifdef PERF_CNT_EN
    // Retired and stall counters; both wrap and freeze naturally once HALTED.
    always_ff @(posedge clk) begin
        if (reset) begin
            retired_count <= '0;
            stall_count   <= '0;
        end else begin
            if (pc_en) begin
                retired_count <= retired_count + CNT_W'(1);
            end
            if (hold) begin
                stall_count <= stall_count + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_cycle_sequencer.sv
// Randomized bench for cycle_sequencer: transaction-level instruction model vs DUT strobes.
// Latency: checks every cycle at negedge+1.
// Backpressure: stalls generated per instruction from fetch/mem/busy wait counts.
import cpu_pkg::*;

module tb_cycle_sequencer;

    localparam int TB_CNT_W = 4;

    logic        clk;
    logic        reset;
    logic        waitrequest;
    logic [31:0] readdata;
    logic [6:0]  instruction_code;
    logic        mem_op;
    logic        muldiv_busy;
    logic        halt_req;
    logic        fetch;
    logic        exec_one;
    logic        exec_two;
    logic        instr_read;
    logic [31:0] instruction;
    logic        pc_en;
    logic        active;
`ifdef PERF_CNT_EN
    logic [TB_CNT_W-1:0] retired_count;
    logic [TB_CNT_W-1:0] stall_count;
`endif

    int          n_total;
    int          n_bad;
    int          exp_ret;
    int          exp_stl;
    logic [31:0] ir_model;
    bit          halted;

    logic [6:0]  codes [8];

    cycle_sequencer #(
        .IR_RESET (32'h0000_0000)
`ifdef PERF_CNT_EN
        ,
        .CNT_W    (TB_CNT_W)
`endif
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .waitrequest      (waitrequest),
        .readdata         (readdata),
        .instruction_code (instruction_code),
        .mem_op           (mem_op),
        .muldiv_busy      (muldiv_busy),
        .halt_req         (halt_req),
        .fetch            (fetch),
        .exec_one         (exec_one),
        .exec_two         (exec_two),
        .instr_read       (instr_read),
        .instruction      (instruction),
        .pc_en            (pc_en),
        .active           (active)
`ifdef PERF_CNT_EN
        ,
        .retired_count    (retired_count),
        .stall_count      (stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Compare every observable output against the instruction-level model.
    task automatic check_cycle(input string tag, input bit f, input bit e1, input bit e2,
                               input bit pc, input bit act);
        check({tag, ".fetch"},    32'(fetch),      32'(f));
        check({tag, ".exec_one"}, 32'(exec_one),   32'(e1));
        check({tag, ".exec_two"}, 32'(exec_two),   32'(e2));
        check({tag, ".pc_en"},    32'(pc_en),      32'(pc));
        check({tag, ".active"},   32'(active),     32'(act));
        check({tag, ".ireq"},     32'(instr_read), 32'(f));
        check({tag, ".ir"},       instruction,     ir_model);
`ifdef PERF_CNT_EN
        check({tag, ".retired"}, 32'(retired_count), 32'(exp_ret % (1 << TB_CNT_W)));
        check({tag, ".stalls"},  32'(stall_count),   32'(exp_stl % (1 << TB_CNT_W)));
`endif
    endtask

    task automatic randomize_inputs();
        waitrequest      = 1'($urandom);
        readdata         = $urandom;
        mem_op           = 1'($urandom);
        muldiv_busy      = 1'($urandom);
        halt_req         = 1'($urandom);
        instruction_code = 7'($urandom_range(0, 10));
    endtask

    // Two reset cycles with random inputs; the second shows the reset state.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        randomize_inputs();
        #1 check("rst.pc_en", 32'(pc_en), 32'd0);
        @(negedge clk);
        randomize_inputs();
        ir_model = 32'h0;
        exp_ret  = 0;
        exp_stl  = 0;
        halted   = 1'b0;
        #1 check_cycle("rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // One instruction: fw fetch waits, then EXEC1, then EXEC2 with w memory
    // waits (count only if mem) and b busy cycles; optional reset mid-EXEC2.
    task automatic run_instr(input logic [31:0] data, input int fw, input int w, input int b,
                             input bit mem, input bit halt, input logic [6:0] code,
                             input bit abort);
        int hold;
        int abort_at;
        hold = b;
        if (mem && w > hold) hold = w;
        abort_at = abort ? int'($urandom_range(0, hold)) : -1;

        for (int k = 0; k <= fw; k++) begin
            @(negedge clk);
            randomize_inputs();
            reset       = 1'b0;
            waitrequest = (k < fw);
            readdata    = (k < fw) ? $urandom : data;
            #1 check_cycle("fetch", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
            if (k < fw) exp_stl++;
        end
        ir_model = data;

        @(negedge clk);
        randomize_inputs();
        #1 check_cycle("exec1", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

        for (int k = 0; k <= hold; k++) begin
            @(negedge clk);
            readdata         = $urandom;
            mem_op           = mem;
            instruction_code = code;
            waitrequest      = (k < w);
            muldiv_busy      = (k < b);
            halt_req         = (k < hold) ? (halt ? 1'b1 : 1'($urandom)) : halt;
            if (k == abort_at) begin
                reset = 1'b1;
                #1 check("abort.pc_en", 32'(pc_en), 32'd0);
                @(posedge clk);
                ir_model = 32'h0;
                exp_ret  = 0;
                exp_stl  = 0;
                return;
            end
            #1 check_cycle("exec2", 1'b0, 1'b0, 1'b1, (k == hold), 1'b1);
            if (k < hold) exp_stl++;
            else          exp_ret++;
        end
        halted = halt;
    endtask

    task automatic run_halted(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            randomize_inputs();
            reset = 1'b0;
            #1 check_cycle("halted", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic random_instr(input bit allow_halt, input bit allow_abort);
        logic [6:0] c;
        bit         m;
        c = codes[$urandom_range(0, 7)];
        m = 1'($urandom);
        if (c == 7'(J) || c == 7'(JAL) || c == 7'(JR) || c == 7'(JALR)) m = 1'b0;
        run_instr($urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  m, allow_halt && ($urandom_range(0, 7) == 0), c,
                  allow_abort && ($urandom_range(0, 7) == 0));
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        codes   = '{7'(ADDIU), 7'(LW), 7'(SW), 7'(J), 7'(JR), 7'(MULT), 7'(BEQ), 7'(JALR)};
        reset = 1'b1;
        waitrequest = 1'b0; readdata = '0; instruction_code = '0;
        mem_op = 1'b0; muldiv_busy = 1'b0; halt_req = 1'b0;
        exp_ret = 0; exp_stl = 0; ir_model = '0; halted = 1'b0;

        do_reset();
        // Plain ADDIU with no stalls.
        run_instr(32'h2408_0005, 0, 0, 0, 1'b0, 1'b0, 7'(ADDIU), 1'b0);
        // Three fetch wait cycles.
        run_instr(32'h8c09_0004, 3, 0, 0, 1'b0, 1'b0, 7'(ADDIU), 1'b0);
        // LW stalled two EXEC2 cycles on memory.
        run_instr(32'h8c0a_0008, 0, 2, 0, 1'b1, 1'b0, 7'(LW), 1'b0);
        // Busy multiplier with halt pending: halt waits for busy to drop.
        run_instr(32'h0000_0018, 0, 0, 4, 1'b0, 1'b1, 7'(MULT), 1'b0);
        run_halted(4);
        do_reset();
        // Reset lands in a stalled EXEC2.
        run_instr(32'h8c0b_000c, 0, 3, 0, 1'b1, 1'b0, 7'(LW), 1'b0);
        run_instr(32'h8c0b_0010, 0, 3, 0, 1'b1, 1'b0, 7'(LW), 1'b1);

        // Seventeen retirements wraps a 4-bit retired counter to 1.
        do_reset();
        for (int i = 0; i < 17; i++) random_instr(1'b0, 1'b0);
`ifdef PERF_CNT_EN
        @(posedge clk);
        #1 check("wrap17", 32'(retired_count), 32'd1);
`endif

        for (int i = 0; i < 60; i++) begin
            random_instr(1'b1, 1'b1);
            if (halted) begin
                run_halted(3);
                do_reset();
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
